// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot gate logic: controller states,
// slot geometry and the encoding of the grant direction.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        HOLD   = 2'd2,
        COMMIT = 2'd3
    } gate_state_t;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    localparam logic DIR_ENTRY = 1'b1;
    localparam logic DIR_EXIT  = 1'b0;

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-zero priority encoder over the occupancy vector. Returns the
// lowest-numbered free slot and flags when no slot is free.
module free_slot_finder
    import parking_pkg::*;
(
    input  logic [SLOTS-1:0]  occupancy,
    output logic [SLOT_W-1:0] slot,
    output logic              none_free
);

    // Scan from the top down so the lowest free index is written last and wins
    always_comb begin
        slot      = '0;
        none_free = 1'b1;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                slot      = SLOT_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gate_arbiter.sv
// Sequencing controller for the single parking gate. Latches entry/exit
// requests, arbitrates them round-robin, holds the door for OPEN_TICKS slow
// ticks and then commits the change to the occupancy register it owns.
// Optional feature: define GATE_ARB_STATS_EN to add the served_count and
// reject_count statistics outputs.
module gate_arbiter
    import parking_pkg::*;
#(
    parameter int OPEN_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              entry_req,
    input  logic              exit_req,
    input  logic [SLOT_W-1:0] exit_slot,
    output logic [SLOTS-1:0]  occupancy,
    output logic [2:0]        free_count,
    output logic              full,
    output logic              door_open,
    output logic              grant_dir,
    output logic [SLOT_W-1:0] grant_slot,
    output logic              busy,
    output logic              reject_pulse,
    output logic              err_pulse
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [7:0]        served_count,
    output logic [7:0]        reject_count
`endif
);

    gate_state_t       state_q, state_d;
    logic [SLOTS-1:0]  occupancy_q, occupancy_d;
    logic              entry_prev_q, entry_prev_d;
    logic              exit_prev_q, exit_prev_d;
    logic              pend_entry_q, pend_entry_d;
    logic              pend_exit_q, pend_exit_d;
    logic [SLOT_W-1:0] pend_slot_q, pend_slot_d;
    logic              rr_exit_q, rr_exit_d;
    logic [3:0]        tick_cnt_q, tick_cnt_d;
    logic              grant_dir_q, grant_dir_d;
    logic [SLOT_W-1:0] grant_slot_q, grant_slot_d;
    logic              reject_q, reject_d;
    logic              err_q, err_d;

    logic [SLOT_W-1:0] free_slot;
    logic              none_free;
    logic              pick_exit;

    free_slot_finder u_finder (
        .occupancy (occupancy_q),
        .slot      (free_slot),
        .none_free (none_free)
    );

    // Request capture, arbitration and the door sequence
    always_comb begin
        state_d      = state_q;
        occupancy_d  = occupancy_q;
        entry_prev_d = entry_req;
        exit_prev_d  = exit_req;
        pend_entry_d = pend_entry_q;
        pend_exit_d  = pend_exit_q;
        pend_slot_d  = pend_slot_q;
        rr_exit_d    = rr_exit_q;
        tick_cnt_d   = tick_cnt_q;
        grant_dir_d  = grant_dir_q;
        grant_slot_d = grant_slot_q;
        reject_d     = 1'b0;
        err_d        = 1'b0;
        pick_exit    = pend_exit_q && (!pend_entry_q || rr_exit_q);

        if (entry_req && !entry_prev_q && !pend_entry_q) begin
            pend_entry_d = 1'b1;
        end
        if (exit_req && !exit_prev_q && !pend_exit_q) begin
            pend_exit_d = 1'b1;
            pend_slot_d = exit_slot;
        end

        case (state_q)
            IDLE: begin
                if (pend_entry_q || pend_exit_q) begin
                    if (pick_exit) begin
                        if (!occupancy_q[pend_slot_q]) begin
                            err_d       = 1'b1;
                            pend_exit_d = 1'b0;
                        end else begin
                            grant_dir_d  = DIR_EXIT;
                            grant_slot_d = pend_slot_q;
                            state_d      = GRANT;
                        end
                    end else begin
                        if (none_free) begin
                            reject_d     = 1'b1;
                            pend_entry_d = 1'b0;
                        end else begin
                            grant_dir_d  = DIR_ENTRY;
                            grant_slot_d = free_slot;
                            state_d      = GRANT;
                        end
                    end
                end
            end
            GRANT: begin
                tick_cnt_d = '0;
                state_d    = HOLD;
            end
            HOLD: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q + 4'd1 == 4'(OPEN_TICKS)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                occupancy_d[grant_slot_q] = grant_dir_q;
                if (grant_dir_q == DIR_ENTRY) begin
                    pend_entry_d = 1'b0;
                    rr_exit_d    = 1'b1;
                end else begin
                    pend_exit_d = 1'b0;
                    rr_exit_d   = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers; reset discards pending and in-flight work
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            occupancy_q  <= '0;
            entry_prev_q <= 1'b0;
            exit_prev_q  <= 1'b0;
            pend_entry_q <= 1'b0;
            pend_exit_q  <= 1'b0;
            pend_slot_q  <= '0;
            rr_exit_q    <= 1'b1;
            tick_cnt_q   <= '0;
            grant_dir_q  <= 1'b0;
            grant_slot_q <= '0;
            reject_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            occupancy_q  <= occupancy_d;
            entry_prev_q <= entry_prev_d;
            exit_prev_q  <= exit_prev_d;
            pend_entry_q <= pend_entry_d;
            pend_exit_q  <= pend_exit_d;
            pend_slot_q  <= pend_slot_d;
            rr_exit_q    <= rr_exit_d;
            tick_cnt_q   <= tick_cnt_d;
            grant_dir_q  <= grant_dir_d;
            grant_slot_q <= grant_slot_d;
            reject_q     <= reject_d;
            err_q        <= err_d;
        end
    end

    // Count the free slots from the registered occupancy
    always_comb begin
        free_count = '0;
        for (int i = 0; i < SLOTS; i++) begin
            free_count = free_count + {2'b00, ~occupancy_q[i]};
        end
    end

    assign occupancy    = occupancy_q;
    assign full         = none_free;
    assign door_open    = (state_q == GRANT) || (state_q == HOLD);
    assign grant_dir    = grant_dir_q;
    assign grant_slot   = grant_slot_q;
    assign busy         = (state_q != IDLE);
    assign reject_pulse = reject_q;
    assign err_pulse    = err_q;

`ifdef GATE_ARB_STATS_EN
    logic [7:0] served_q, served_d;
    logic [7:0] refused_q, refused_d;

    // Next values of the wrapping grant and refusal counters
    always_comb begin
        served_d  = served_q;
        refused_d = refused_q;
        if (state_q == COMMIT) begin
            served_d = served_q + 8'd1;
        end
        if (reject_d || err_d) begin
            refused_d = refused_q + 8'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served_q  <= '0;
            refused_q <= '0;
        end else begin
            served_q  <= served_d;
            refused_q <= refused_d;
        end
    end

    assign served_count = served_q;
    assign reject_count = refused_q;
`endif

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed testbench for gate_arbiter built with OPEN_TICKS = 2. Each task
// drives one scenario and checks hand-derived expected values. When
// GATE_ARB_STATS_EN is defined the statistics counters are checked as well.
module tb_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic [3:0] occupancy;
    logic [2:0] free_count;
    logic       full;
    logic       door_open;
    logic       grant_dir;
    logic [1:0] grant_slot;
    logic       busy;
    logic       reject_pulse;
    logic       err_pulse;
`ifdef GATE_ARB_STATS_EN
    logic [7:0] served_count;
    logic [7:0] reject_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    gate_arbiter #(.OPEN_TICKS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .exit_slot    (exit_slot),
        .occupancy    (occupancy),
        .free_count   (free_count),
        .full         (full),
        .door_open    (door_open),
        .grant_dir    (grant_dir),
        .grant_slot   (grant_slot),
        .busy         (busy),
        .reject_pulse (reject_pulse),
        .err_pulse    (err_pulse)
`ifdef GATE_ARB_STATS_EN
        ,
        .served_count (served_count),
        .reject_count (reject_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle entry request; afterwards the request is pending
    task automatic pulse_entry();
        entry_req = 1'b1;
        cycle();
        entry_req = 1'b0;
    endtask

    // One-cycle exit request for the given slot
    task automatic pulse_exit(input logic [1:0] slot);
        exit_slot = slot;
        exit_req  = 1'b1;
        cycle();
        exit_req  = 1'b0;
    endtask

    // Feed ticks until the controller returns to IDLE, with a cycle budget
    task automatic finish_grant(output bit ok);
        for (int i = 0; i < 40; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            cycle();
            if (!busy) break;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle();
        cycle();
        tests_run++;
        if (occupancy !== 4'b0000 || free_count !== 3'd4 || full !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_occ: occ=%b free=%0d full=%b, required 0000/4/0", occupancy, free_count, full);
        end
        tests_run++;
        if (door_open !== 1'b0 || grant_dir !== 1'b0 || grant_slot !== 2'd0 || busy !== 1'b0
            || reject_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: door=%b dir=%b slot=%0d busy=%b rej=%b err=%b, required all 0",
                     door_open, grant_dir, grant_slot, busy, reject_pulse, err_pulse);
        end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_entry_grant();
        pulse_entry();
        tests_run++;
        if (door_open !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL entry_pending_idle: door=%b busy=%b, required 0/0", door_open, busy);
        end
        tick = 1'b1;
        cycle();
        tests_run++;
        if (door_open !== 1'b1 || grant_dir !== 1'b1 || grant_slot !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL entry_grant: door=%b dir=%b slot=%0d, required 1/1/0", door_open, grant_dir, grant_slot);
        end
        cycle();
        tick = 1'b0;
        tests_run++;
        if (door_open !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold_open: door=%b, required 1", door_open);
        end
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
        tests_run++;
        if (door_open !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL grant_tick_ignored: door=%b after first counted tick, required 1", door_open);
        end
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        tests_run++;
        if (door_open !== 1'b0 || busy !== 1'b1 || occupancy !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL commit_state: door=%b busy=%b occ=%b, required 0/1/0000", door_open, busy, occupancy);
        end
        cycle();
        tests_run++;
        if (occupancy !== 4'b0001 || free_count !== 3'd3 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL entry_commit: occ=%b free=%0d busy=%b, required 0001/3/0", occupancy, free_count, busy);
        end
    endtask

    task automatic test_err_exit();
        pulse_exit(2'd3);
        tests_run++;
        if (err_pulse !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_early: err=%b, required 0", err_pulse);
        end
        cycle();
        tests_run++;
        if (err_pulse !== 1'b1 || door_open !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_pulse: err=%b door=%b busy=%b, required 1/0/0", err_pulse, door_open, busy);
        end
        cycle();
        tests_run++;
        if (err_pulse !== 1'b0 || door_open !== 1'b0 || occupancy !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL err_one_cycle: err=%b door=%b occ=%b, required 0/0/0001", err_pulse, door_open, occupancy);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        pulse_entry();
        finish_grant(ok);
        tests_run++;
        if (!ok || occupancy !== 4'b0011) begin
            tests_failed++;
            $display("[TB] FAIL sim_setup: ok=%0d occ=%b, required 1/0011", ok, occupancy);
        end
        exit_slot = 2'd1;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        cycle();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        cycle();
        tests_run++;
        if (door_open !== 1'b1 || grant_dir !== 1'b0 || grant_slot !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL sim_exit_first: door=%b dir=%b slot=%0d, required 1/0/1", door_open, grant_dir, grant_slot);
        end
        finish_grant(ok);
        tests_run++;
        if (!ok || occupancy !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL sim_exit_commit: ok=%0d occ=%b, required 1/0001", ok, occupancy);
        end
        cycle();
        tests_run++;
        if (door_open !== 1'b1 || grant_dir !== 1'b1 || grant_slot !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL sim_entry_second: door=%b dir=%b slot=%0d, required 1/1/1", door_open, grant_dir, grant_slot);
        end
        finish_grant(ok);
        tests_run++;
        if (!ok || occupancy !== 4'b0011) begin
            tests_failed++;
            $display("[TB] FAIL sim_final: ok=%0d occ=%b, required 1/0011", ok, occupancy);
        end
    endtask

    task automatic test_fill_and_reject();
        bit ok;
        pulse_entry();
        finish_grant(ok);
        pulse_entry();
        finish_grant(ok);
        tests_run++;
        if (!ok || occupancy !== 4'b1111 || full !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fill_full: ok=%0d occ=%b full=%b, required 1/1111/1", ok, occupancy, full);
        end
        pulse_exit(2'd2);
        finish_grant(ok);
        tests_run++;
        if (!ok || occupancy !== 4'b1011 || full !== 1'b0 || free_count !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL free_slot2: occ=%b full=%b free=%0d, required 1011/0/1", occupancy, full, free_count);
        end
        pulse_entry();
        cycle();
        tests_run++;
        if (door_open !== 1'b1 || grant_dir !== 1'b1 || grant_slot !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL entry_slot2: door=%b dir=%b slot=%0d, required 1/1/2", door_open, grant_dir, grant_slot);
        end
        finish_grant(ok);
        tests_run++;
        if (!ok || occupancy !== 4'b1111 || full !== 1'b1 || free_count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL refill_full: occ=%b full=%b free=%0d, required 1111/1/0", occupancy, full, free_count);
        end
        pulse_entry();
        cycle();
        tests_run++;
        if (reject_pulse !== 1'b1 || door_open !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reject_pulse: rej=%b door=%b, required 1/0", reject_pulse, door_open);
        end
        cycle();
        tests_run++;
        if (reject_pulse !== 1'b0 || occupancy !== 4'b1111 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reject_one_cycle: rej=%b occ=%b busy=%b, required 0/1111/0", reject_pulse, occupancy, busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        pulse_entry();
        cycle();
        cycle();
        tests_run++;
        if (door_open !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold_before_reset: door=%b, required 1", door_open);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (door_open !== 1'b0 || busy !== 1'b0 || occupancy !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: door=%b busy=%b occ=%b, required 0/0/0000", door_open, busy, occupancy);
        end
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            cycle();
        end
        tests_run++;
        if (busy !== 1'b0 || door_open !== 1'b0 || occupancy !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL no_commit_after_reset: busy=%b door=%b occ=%b, required 0/0/0000", busy, door_open, occupancy);
        end
    endtask

`ifdef GATE_ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        tests_run++;
        if (served_count !== 8'd0 || reject_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL stats_reset: served=%0d rejected=%0d, required 0/0", served_count, reject_count);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_entry();
            finish_grant(ok);
        end
        pulse_exit(2'd3);
        cycle();
        cycle();
        tests_run++;
        if (served_count !== 8'd3 || reject_count !== 8'd1 || occupancy !== 4'b0111) begin
            tests_failed++;
            $display("[TB] FAIL stats_counts: served=%0d rejected=%0d occ=%b, required 3/1/0111",
                     served_count, reject_count, occupancy);
        end
    endtask
`endif

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_entry_grant();
        test_err_exit();
        test_simultaneous();
        test_fill_and_reject();
        test_reset_mid_hold();
`ifdef GATE_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
